// File: rtl/rv32i_types.sv
// Shared burst geometry and adaptor state encoding for the cache-line adaptor.
// The cache side moves whole lines; the memory side moves fixed-width beats.
package rv32i_types;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = 4;
    localparam int CNT_W  = 2;

    localparam logic [31:0] LINE_ALIGN_MASK = 32'hFFFF_FFE0;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        READ_BURST  = 2'd1,
        WRITE_BURST = 2'd2,
        DONE        = 2'd3
    } adaptor_state_e;

    // Beat idx occupies line bits [BEAT_W*idx +: BEAT_W]; beat 0 is the low word.
    function automatic logic [BEAT_W-1:0] beat_of(input logic [LINE_W-1:0] line,
                                                  input logic [CNT_W-1:0]  idx);
        return line[idx*BEAT_W +: BEAT_W];
    endfunction

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Bundle of cache-side line signals and memory-side burst signals.
// slave: the adaptor's view; master: the environment (cache plus memory).
interface cacheline_adaptor_if;

    logic                         pmem_read;
    logic                         pmem_write;
    logic [31:0]                  pmem_address;
    logic [rv32i_types::LINE_W-1:0] pmem_wdata;
    logic [rv32i_types::LINE_W-1:0] pmem_rdata;
    logic                         pmem_resp;

    logic                         burst_read;
    logic                         burst_write;
    logic [31:0]                  burst_address;
    logic [rv32i_types::BEAT_W-1:0] burst_wdata;
    logic [rv32i_types::BEAT_W-1:0] burst_rdata;
    logic                         burst_resp;

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp,
        output burst_read, burst_write, burst_address, burst_wdata,
        input  burst_rdata, burst_resp
    );

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp,
        input  burst_read, burst_write, burst_address, burst_wdata,
        output burst_rdata, burst_resp
    );

endinterface

// File: rtl/cacheline_adaptor.sv
// Converts single-cycle cache line requests into four-beat memory bursts.
// Writes win over simultaneous reads; the fill line persists until the next read beat.
module cacheline_adaptor
    import rv32i_types::*;
(
    input  logic                clk,
    input  logic                reset_n,
    cacheline_adaptor_if.slave  bus
);

    adaptor_state_e     r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_addr;
    logic [LINE_W-1:0]  r_rline;
    logic [LINE_W-1:0]  r_wline;

    logic               w_in_burst;
    logic               w_beat;
    logic               w_last_beat;
    logic [LINE_W-1:0]  w_rline_next;

    assign w_in_burst  = (r_state == READ_BURST) || (r_state == WRITE_BURST);
    assign w_beat      = w_in_burst && bus.burst_resp;
    assign w_last_beat = w_beat && (r_cnt == CNT_W'(BEATS - 1));

    // Only the slice addressed by the beat counter can change on a read beat.
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_fill
        assign w_rline_next[gi*BEAT_W +: BEAT_W] =
            ((r_state == READ_BURST) && bus.burst_resp && (r_cnt == CNT_W'(gi)))
                ? bus.burst_rdata
                : r_rline[gi*BEAT_W +: BEAT_W];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_rline <= '0;
            r_wline <= '0;
        end else begin
            r_rline <= w_rline_next;
            if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (bus.pmem_write) begin
                        r_addr  <= bus.pmem_address & LINE_ALIGN_MASK;
                        r_wline <= bus.pmem_wdata;
                        r_cnt   <= '0;
                        r_state <= WRITE_BURST;
                    end else if (bus.pmem_read) begin
                        r_addr  <= bus.pmem_address & LINE_ALIGN_MASK;
                        r_cnt   <= '0;
                        r_state <= READ_BURST;
                    end
                end
                READ_BURST, WRITE_BURST: begin
                    if (w_last_beat) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.pmem_rdata    = r_rline;
    assign bus.pmem_resp     = (r_state == DONE);
    assign bus.burst_read    = (r_state == READ_BURST);
    assign bus.burst_write   = (r_state == WRITE_BURST);
    assign bus.burst_address = r_addr;
    assign bus.burst_wdata   = beat_of(r_wline, r_cnt);

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomised bench for cacheline_adaptor: each transaction is predicted from the
// line contents, the beat arrival pattern and the aligned address alone.
module tb_cacheline_adaptor;

    logic clk = 1'b0;
    logic reset_n;

    cacheline_adaptor_if bus();

    cacheline_adaptor dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    logic [255:0] last_rline;

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = 32'h0;
        bus.pmem_wdata   = '0;
        bus.burst_rdata  = '0;
        bus.burst_resp   = 1'b0;
    endtask

    // One full line transaction; expectations come from line, address and beat order.
    task automatic run_txn(input string tag, input bit wr, input bit both,
                           input logic [31:0] addr, input logic [255:0] line,
                           input logic [15:0] pat, input int pat_len, input int gap_pct,
                           input bit wiggle, input bit keep, output int lat);
        logic [31:0]  exp_addr;
        logic [63:0]  exp_beat;
        logic [255:0] exp_r;
        int k;
        int cyc;
        bit resp;
        exp_addr = {addr[31:5], 5'b0};
        bus.pmem_address = addr;
        bus.pmem_wdata   = wr ? line : rand256();
        bus.pmem_write   = wr;
        bus.pmem_read    = !wr || both;
        bus.burst_resp   = 1'b0;
        step();
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 100) begin
            exp_beat = 64'(line >> (64 * k));
            vectors++;
            if (bus.burst_read !== !wr || bus.burst_write !== wr || bus.pmem_resp !== 1'b0) begin
                miscompares++;
                $display("FAIL %s burst_flags beat%0d: got rd=%b wr=%b resp=%b, want rd=%b wr=%b resp=0",
                         tag, k, bus.burst_read, bus.burst_write, bus.pmem_resp, !wr, wr);
            end
            vectors++;
            if (bus.burst_address !== exp_addr) begin
                miscompares++;
                $display("FAIL %s burst_address: got %h, want %h", tag, bus.burst_address, exp_addr);
            end
            if (wr) begin
                vectors++;
                if (bus.burst_wdata !== exp_beat) begin
                    miscompares++;
                    $display("FAIL %s burst_wdata beat%0d: got %h, want %h", tag, k, bus.burst_wdata, exp_beat);
                end
            end
            if (cyc < pat_len) resp = pat[cyc];
            else               resp = ($urandom_range(99) >= gap_pct);
            bus.burst_resp  = resp;
            bus.burst_rdata = resp ? exp_beat : {$urandom, $urandom};
            if (wiggle) begin
                bus.pmem_address = $urandom;
                bus.pmem_wdata   = rand256();
                bus.pmem_read    = 1'($urandom_range(1));
                bus.pmem_write   = 1'($urandom_range(1));
            end
            step();
            cyc++;
            if (resp) k++;
        end
        bus.burst_resp = 1'b0;
        lat = cyc + 1;
        if (k < 4) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: got %0d beats, want 4", tag, k);
        end
        exp_r = wr ? last_rline : line;
        vectors++;
        if (bus.pmem_resp !== 1'b1 || bus.burst_read !== 1'b0 || bus.burst_write !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_flags: got resp=%b rd=%b wr=%b, want resp=1 rd=0 wr=0",
                     tag, bus.pmem_resp, bus.burst_read, bus.burst_write);
        end
        vectors++;
        if (bus.pmem_rdata !== exp_r) begin
            miscompares++;
            $display("FAIL %s pmem_rdata: got %h, want %h", tag, bus.pmem_rdata, exp_r);
        end
        if (!wr) last_rline = line;
        if (!keep) begin
            bus.pmem_read  = 1'b0;
            bus.pmem_write = 1'b0;
            step();
            vectors++;
            if (bus.pmem_resp !== 1'b0 || bus.burst_read !== 1'b0 || bus.burst_write !== 1'b0) begin
                miscompares++;
                $display("FAIL %s after_done: got resp=%b rd=%b wr=%b, want all 0",
                         tag, bus.pmem_resp, bus.burst_read, bus.burst_write);
            end
            vectors++;
            if (bus.pmem_rdata !== last_rline) begin
                miscompares++;
                $display("FAIL %s rdata_hold: got %h, want %h", tag, bus.pmem_rdata, last_rline);
            end
        end
        $display("txn %-12s %s addr=%h cycles_to_resp=%0d", tag, wr ? "WR" : "RD", addr, lat);
    endtask

    // Idle cycles with stray burst_resp noise that must be ignored.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.burst_resp  = 1'($urandom_range(1));
            bus.burst_rdata = {$urandom, $urandom};
            step();
            vectors++;
            if (bus.pmem_resp !== 1'b0 || bus.burst_read !== 1'b0 || bus.burst_write !== 1'b0
                || bus.pmem_rdata !== last_rline) begin
                miscompares++;
                $display("FAIL idle: got resp=%b rd=%b wr=%b rdata=%h, want 0 0 0 %h",
                         bus.pmem_resp, bus.burst_read, bus.burst_write, bus.pmem_rdata, last_rline);
            end
        end
        bus.burst_resp = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        clear_inputs();
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.pmem_resp !== 1'b0 || bus.burst_read !== 1'b0 || bus.burst_write !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got resp=%b rd=%b wr=%b, want all 0",
                     bus.pmem_resp, bus.burst_read, bus.burst_write);
        end
        vectors++;
        if (bus.burst_address !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_address: got %h, want 0", bus.burst_address);
        end
        vectors++;
        if (bus.pmem_rdata !== 256'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h, want 0", bus.pmem_rdata);
        end
        last_rline = '0;
        step();
        step();
        #3 reset_n = 1'b1;
        $display("txn %-12s reset released", "reset");
    endtask

    task automatic test_read();
        int lat;
        logic [255:0] line;
        line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        run_txn("read", 1'b0, 1'b0, 32'h0000_1234, line, 16'h000F, 4, 0, 1'b0, 1'b0, lat);
        vectors++;
        if (lat !== 5) begin
            miscompares++;
            $display("FAIL read_latency: got %0d, want 5", lat);
        end
        vectors++;
        if (dut.bus.burst_address !== 32'h0000_1220) begin
            miscompares++;
            $display("FAIL read_aligned_addr: got %h, want 00001220", bus.burst_address);
        end
    endtask

    task automatic test_write();
        int lat;
        logic [255:0] line;
        line = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        run_txn("write", 1'b1, 1'b0, 32'h8000_0047, line, 16'h000F, 4, 0, 1'b0, 1'b0, lat);
        vectors++;
        if (lat !== 5) begin
            miscompares++;
            $display("FAIL write_latency: got %0d, want 5", lat);
        end
    endtask

    task automatic test_gaps();
        int lat;
        run_txn("gap_read", 1'b0, 1'b0, 32'h0001_0F1F, rand256(), 16'h0059, 7, 0, 1'b0, 1'b0, lat);
        vectors++;
        if (lat !== 8) begin
            miscompares++;
            $display("FAIL gap_latency: got %0d, want 8", lat);
        end
    endtask

    task automatic test_both_high();
        int lat;
        run_txn("both_high", 1'b1, 1'b1, 32'h1234_5678, rand256(), 16'h0, 0, 30, 1'b1, 1'b0, lat);
        idle_cycles(2);
    endtask

    task automatic test_reset_mid_burst();
        logic [255:0] line;
        line = rand256();
        bus.pmem_address = 32'h0000_4000;
        bus.pmem_read    = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            bus.burst_resp  = 1'b1;
            bus.burst_rdata = 64'(line >> (64 * i));
            step();
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.burst_read !== 1'b0 || bus.pmem_resp !== 1'b0 || bus.burst_address !== 32'h0
            || bus.pmem_rdata !== 256'h0) begin
            miscompares++;
            $display("FAIL mid_reset: got rd=%b resp=%b addr=%h rdata=%h, want all 0",
                     bus.burst_read, bus.pmem_resp, bus.burst_address, bus.pmem_rdata);
        end
        last_rline = '0;
        step();
        vectors++;
        if (bus.pmem_resp !== 1'b0 || bus.burst_read !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_hold: got resp=%b rd=%b, want 0 0", bus.pmem_resp, bus.burst_read);
        end
        bus.burst_resp = 1'b0;
        #3 reset_n = 1'b1;
        $display("txn %-12s reset during read burst", "mid_reset");
    endtask

    task automatic test_back_to_back();
        int lat;
        run_txn("b2b_first", 1'b0, 1'b0, 32'h0000_2000, rand256(), 16'h0, 0, 20, 1'b0, 1'b1, lat);
        bus.pmem_address = 32'h0000_3000;
        step();
        vectors++;
        if (bus.burst_read !== 1'b0 || bus.pmem_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: got rd=%b resp=%b, want 0 0", bus.burst_read, bus.pmem_resp);
        end
        run_txn("b2b_second", 1'b0, 1'b0, 32'h0000_3000, rand256(), 16'h0, 0, 20, 1'b0, 1'b0, lat);
    endtask

    task automatic test_random();
        int lat;
        bit wr;
        bit both;
        for (int t = 0; t < 24; t++) begin
            wr   = 1'($urandom_range(1));
            both = wr && ($urandom_range(3) == 0);
            run_txn("random", wr, both, $urandom, rand256(), 16'h0, 0,
                    int'($urandom_range(60)), 1'b1, 1'b0, lat);
            idle_cycles(int'($urandom_range(3)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_gaps();
        test_both_high();
        test_reset_mid_burst();
        test_read();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
